// File: rtl/pipelined_segment_adder_if.sv
// Handshake and data bundle for pipelined_segment_adder.
// The slave modport is the adder side; the master modport is the producer/consumer side.
interface pipelined_segment_adder_if #(
    parameter int N   = 16,
    parameter int SEG = 4
);
    localparam int NSEG = N / SEG;
    localparam int CW   = $clog2(NSEG + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic          Cin;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  S;
    logic          Cout;
    logic [N-1:0]  P;
    logic [CW-1:0] cycles;

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, Cout, P, cycles
    );

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, Cout, P, cycles
    );
endinterface

// File: rtl/pipelined_segment_adder.sv
// Multi-cycle adder: adds SEG bits per clock through an IDLE/RUN/DONE FSM.
// Optional macro EARLY_DONE_EN ends RUN once no carry can reach the upper segments.
module pipelined_segment_adder #(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input logic                     clk,
    input logic                     rst_n,
    pipelined_segment_adder_if.slave bus
);
    localparam int NSEG = N / SEG;
    localparam int IDXW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int CW   = $clog2(NSEG + 1);
    localparam logic [IDXW-1:0] LAST = IDXW'(NSEG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [N-1:0]    a_r;
    logic [N-1:0]    b_r;
    logic            carry;
    logic [IDXW-1:0] idx;

    logic [SEG-1:0]  a_seg;
    logic [SEG-1:0]  b_seg;
    logic [SEG:0]    sum;
    logic [N-1:0]    s_next;
    logic            last;
    logic            early;
`ifdef EARLY_DONE_EN
    logic [N-1:0]    upper_mask;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);

    always_comb begin
        a_seg  = a_r[idx*SEG +: SEG];
        b_seg  = b_r[idx*SEG +: SEG];
        sum    = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, carry};
        s_next = bus.S;
        s_next[idx*SEG +: SEG] = sum[SEG-1:0];
        last   = (idx == LAST);
        early  = 1'b0;
`ifdef EARLY_DONE_EN
        // No carry out of segment k and no generate above it: upper sum bits are just A^B.
        upper_mask = {N{1'b1}} << ((int'(idx) + 1) * SEG);
        if (!last && !sum[SEG] && ((a_r & b_r & upper_mask) == '0)) begin
            early  = 1'b1;
            s_next = (s_next & ~upper_mask) | ((a_r ^ b_r) & upper_mask);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            carry      <= 1'b0;
            idx        <= '0;
            bus.S      <= '0;
            bus.Cout   <= 1'b0;
            bus.P      <= '0;
            bus.cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.A;
                        b_r        <= bus.B;
                        carry      <= bus.Cin;
                        bus.P      <= bus.A ^ bus.B;
                        bus.S      <= '0;
                        bus.Cout   <= 1'b0;
                        bus.cycles <= '0;
                        idx        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    bus.S      <= s_next;
                    carry      <= sum[SEG];
                    bus.cycles <= bus.cycles + CW'(1);
                    if (last || early) begin
                        bus.Cout <= early ? 1'b0 : sum[SEG];
                        state    <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Scoreboard bench for pipelined_segment_adder (N=16, SEG=4); honours EARLY_DONE_EN.
module tb_pipelined_segment_adder;
    localparam int N    = 16;
    localparam int SEG  = 4;
    localparam int NSEG = N / SEG;
    localparam int CW   = $clog2(NSEG + 1);

    typedef struct packed {
        logic [N-1:0]  s;
        logic          cout;
        logic [N-1:0]  p;
        logic [CW-1:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int unsigned vec = 0;
    int unsigned err = 0;

    pipelined_segment_adder_if #(.N(N), .SEG(SEG)) bus ();

    pipelined_segment_adder #(.N(N), .SEG(SEG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin);
        exp_t m;
        logic [N:0] full;
        full   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        m.s    = full[N-1:0];
        m.cout = full[N];
        m.p    = a ^ b;
        m.cyc  = CW'(NSEG);
`ifdef EARLY_DONE_EN
        begin
            logic c;
            logic found;
            logic [SEG:0] ss;
            logic [N-1:0] sa, sbb, hi;
            c = cin;
            found = 1'b0;
            for (int k = 0; k < NSEG - 1; k++) begin
                sa  = a >> (k * SEG);
                sbb = b >> (k * SEG);
                ss  = {1'b0, sa[SEG-1:0]} + {1'b0, sbb[SEG-1:0]} + {{SEG{1'b0}}, c};
                c   = ss[SEG];
                hi  = (a & b) >> ((k + 1) * SEG);
                if (!found && !c && hi == '0) begin
                    found = 1'b1;
                    m.cyc = CW'(k + 1);
                end
            end
        end
`endif
        return m;
    endfunction

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.Cin = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vec++;
        if ({bus.in_ready, bus.out_valid, bus.S, bus.Cout, bus.P, bus.cycles} !==
            {1'b1, 1'b0, {N{1'b0}}, 1'b0, {N{1'b0}}, {CW{1'b0}}}) begin
            $display("FAIL reset_state got rdy=%b vld=%b S=%h Cout=%b P=%h cyc=%0d want rdy=1 vld=0 all zero",
                     bus.in_ready, bus.out_valid, bus.S, bus.Cout, bus.P, bus.cycles);
            err++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Accept one operation, check result and latency, hold DONE for `stall` cycles, then release.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                          input int unsigned stall, input string tag);
        exp_t e;
        int unsigned n;
        n = 0;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        vec++;
        if (bus.in_ready !== 1'b1) begin
            $display("FAIL %s_in_ready got %b want 1", tag, bus.in_ready);
            err++;
            return;
        end
        bus.A = a; bus.B = b; bus.Cin = cin; bus.in_valid = 1'b1;
        sb.push_back(model(a, b, cin));
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            bus.A = N'($urandom); bus.B = N'($urandom);
            bus.Cin = 1'($urandom); bus.in_valid = 1'($urandom);
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        e = sb.pop_front();
        vec++;
        if (bus.out_valid !== 1'b1) begin
            $display("FAIL %s_out_valid_timeout got %b want 1", tag, bus.out_valid);
            err++;
            return;
        end
        vec++;
        if (n !== int'(e.cyc)) begin
            $display("FAIL %s_latency got %0d edges want %0d", tag, n, e.cyc);
            err++;
        end
        vec++;
        if (bus.S !== e.s) begin
            $display("FAIL %s_S got %h want %h", tag, bus.S, e.s); err++;
        end
        vec++;
        if (bus.Cout !== e.cout) begin
            $display("FAIL %s_Cout got %b want %b", tag, bus.Cout, e.cout); err++;
        end
        vec++;
        if (bus.P !== e.p) begin
            $display("FAIL %s_P got %h want %h", tag, bus.P, e.p); err++;
        end
        vec++;
        if (bus.cycles !== e.cyc) begin
            $display("FAIL %s_cycles got %0d want %0d", tag, bus.cycles, e.cyc); err++;
        end
        for (int unsigned i = 0; i < stall; i++) begin
            bus.A = N'($urandom); bus.B = N'($urandom); bus.in_valid = ~bus.in_valid;
            @(negedge clk);
            vec++;
            if ({bus.S, bus.Cout, bus.P, bus.cycles, bus.in_ready, bus.out_valid} !==
                {e.s, e.cout, e.p, e.cyc, 1'b0, 1'b1}) begin
                $display("FAIL %s_hold got S=%h Cout=%b P=%h cyc=%0d rdy=%b vld=%b want S=%h Cout=%b P=%h cyc=%0d rdy=0 vld=1",
                         tag, bus.S, bus.Cout, bus.P, bus.cycles, bus.in_ready, bus.out_valid,
                         e.s, e.cout, e.p, e.cyc);
                err++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        vec++;
        if ({bus.in_ready, bus.out_valid, bus.S, bus.Cout, bus.cycles} !== {1'b1, 1'b0, e.s, e.cout, e.cyc}) begin
            $display("FAIL %s_release got rdy=%b vld=%b S=%h Cout=%b cyc=%0d want rdy=1 vld=0 S=%h Cout=%b cyc=%0d",
                     tag, bus.in_ready, bus.out_valid, bus.S, bus.Cout, bus.cycles, e.s, e.cout, e.cyc);
            err++;
        end
    endtask

    task automatic test_vectors();
        run_op(16'h9C94, 16'h636A, 1'b1, 0, "v_9c94");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, "v_ffff");
        run_op(16'h0001, 16'h0001, 1'b0, 0, "v_0001");
        run_op(16'h0000, 16'h0000, 1'b0, 0, "v_zero");
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, "v_ripple");
        run_op(16'h00F0, 16'h0010, 1'b0, 0, "v_mid");
    endtask

    task automatic test_hold();
        run_op(16'h1234, 16'h8765, 1'b1, 5, "hold");
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        bus.A = 16'hFFFF; bus.B = 16'h0001; bus.Cin = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec++;
        if ({bus.in_ready, bus.out_valid, bus.S, bus.Cout, bus.P, bus.cycles} !==
            {1'b1, 1'b0, {N{1'b0}}, 1'b0, {N{1'b0}}, {CW{1'b0}}}) begin
            $display("FAIL abort_reset got rdy=%b vld=%b S=%h Cout=%b P=%h cyc=%0d want rdy=1 vld=0 all zero",
                     bus.in_ready, bus.out_valid, bus.S, bus.Cout, bus.P, bus.cycles);
            err++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        vec++;
        if (seen !== 1'b0) begin
            $display("FAIL abort_no_partial got out_valid=1 want 0");
            err++;
        end
        run_op(16'h0F0F, 16'h00F1, 1'b0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++)
            run_op(N'($urandom), N'($urandom), 1'($urandom), i % 3, "b2b");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
